// File: rtl/sys_bus_bridge_if.sv
// CPU-side request/ack signals plus the peripheral register bus (ADD/WE/DAT/BE/IRQ).
// The bridge initiates peripheral cycles, so it takes the master view.
interface sys_bus_bridge_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic [1:0]  ADD_O;
  logic        WE0_O;
  logic        WE1_O;
  logic [31:0] DAT_O;
  logic [3:0]  BE_O;
  logic [31:0] DAT0_I;
  logic [31:0] DAT1_I;
  logic        IRQ0_I;
  logic        IRQ1_I;
  logic [5:0]  HWINT_O;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    input  DAT0_I, DAT1_I, IRQ0_I, IRQ1_I,
    output cpu_ack, cpu_err, cpu_rdata,
    output ADD_O, WE0_O, WE1_O, DAT_O, BE_O, HWINT_O
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
    output DAT0_I, DAT1_I, IRQ0_I, IRQ1_I,
    input  cpu_ack, cpu_err, cpu_rdata,
    input  ADD_O, WE0_O, WE1_O, DAT_O, BE_O, HWINT_O
  );
endinterface

// File: rtl/sys_bus_bridge.sv
// Single-word CPU load/store bridge onto a two-window peripheral register bus, with IRQ capture.
// Latency: strobe/read one cycle after the request is latched, ack the cycle after (error: ack next cycle).
// Backpressure: CPU holds cpu_req until cpu_ack; requests are sampled only in IDLE.
module sys_bus_bridge #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  sys_bus_bridge_if.master      bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef struct packed {
    logic [1:0]  word;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        sel1;
  } req_t;

  logic [1:0] state;
  req_t       lat;
  logic       hit0;
  logic       hit1;
  logic       be_ok;
  logic       req_bad;
  logic       unused_addr;

  assign hit0 = (bus.cpu_addr[31:4] == DEV0_BASE[31:4]);
  assign hit1 = (bus.cpu_addr[31:4] == DEV1_BASE[31:4]);
  assign unused_addr = ^bus.cpu_addr[1:0];

  // Only naturally aligned byte, halfword and word lanes are accepted.
  always_comb begin
    be_ok = 1'b0;
    case (bus.cpu_be)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: be_ok = 1'b1;
      default:                            be_ok = 1'b0;
    endcase
  end

  assign req_bad = !(hit0 || hit1) || !be_ok;

  assign bus.ADD_O = lat.word;
  assign bus.BE_O  = lat.be;
  assign bus.DAT_O = lat.wdata;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state         <= ST_IDLE;
      lat           <= '0;
      bus.WE0_O     <= 1'b0;
      bus.WE1_O     <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      bus.WE0_O   <= 1'b0;
      bus.WE1_O   <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.cpu_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cpu_req) begin
            lat.word  <= bus.cpu_addr[3:2];
            lat.be    <= bus.cpu_be;
            lat.wdata <= bus.cpu_wdata;
            lat.sel1  <= hit1;
            if (req_bad) begin
              state         <= ST_RESP;
              bus.cpu_ack   <= 1'b1;
              bus.cpu_err   <= 1'b1;
              bus.cpu_rdata <= '0;
            end else if (bus.cpu_we) begin
              state     <= ST_WR;
              bus.WE0_O <= hit0;
              bus.WE1_O <= hit1;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_WR: begin
          state         <= ST_RESP;
          bus.cpu_ack   <= 1'b1;
          bus.cpu_rdata <= '0;
        end
        ST_RD: begin
          state         <= ST_RESP;
          bus.cpu_ack   <= 1'b1;
          bus.cpu_rdata <= lat.sel1 ? bus.DAT1_I : bus.DAT0_I;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Interrupts bypass the FSM entirely.
  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      bus.HWINT_O <= '0;
    end else begin
      bus.HWINT_O <= {4'b0000, bus.IRQ1_I, bus.IRQ0_I};
    end
  end

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Randomized and directed bench for sys_bus_bridge against a word-array reference of both device windows.
module tb_sys_bus_bridge;
  logic CLK_I = 1'b0;
  logic RST_I = 1'b0;

  sys_bus_bridge_if bus ();

  sys_bus_bridge #(
    .DEV0_BASE(32'h0000_7F00),
    .DEV1_BASE(32'h0000_7F10)
  ) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .bus  (bus)
  );

  always #5 CLK_I = ~CLK_I;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] dev0 [4];
  logic [31:0] dev1 [4];
  logic [31:0] ref0 [4];
  logic [31:0] ref1 [4];

  int          we0_cnt = 0;
  int          we1_cnt = 0;
  logic [1:0]  last_add;
  logic [31:0] last_dat;
  logic [3:0]  last_be;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic legal_be(input logic [3:0] be);
    return (be == 4'b1111) || (be == 4'b0011) || (be == 4'b1100) ||
           (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000);
  endfunction

  // Peripheral devices: combinational read, byte-merged write on the strobe.
  assign bus.DAT0_I = dev0[bus.ADD_O];
  assign bus.DAT1_I = dev1[bus.ADD_O];

  always @(posedge CLK_I) begin
    cyc <= cyc + 1;
    if (bus.WE0_O) dev0[bus.ADD_O] <= merge(dev0[bus.ADD_O], bus.DAT_O, bus.BE_O);
    if (bus.WE1_O) dev1[bus.ADD_O] <= merge(dev1[bus.ADD_O], bus.DAT_O, bus.BE_O);
  end

  always @(negedge CLK_I) begin
    if (bus.WE0_O) we0_cnt++;
    if (bus.WE1_O) we1_cnt++;
    if (bus.WE0_O || bus.WE1_O) begin
      last_add = bus.ADD_O;
      last_dat = bus.DAT_O;
      last_be  = bus.BE_O;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd);
    logic        h0, h1, err;
    logic [1:0]  w;
    logic [31:0] exp_rd;
    int          s0, s1, n;
    logic        got_ack, a_err;
    logic [31:0] a_rd;
    h0  = (addr >= 32'h0000_7F00) && (addr < 32'h0000_7F10);
    h1  = (addr >= 32'h0000_7F10) && (addr < 32'h0000_7F20);
    err = !(h0 || h1) || !legal_be(be);
    w   = addr[3:2];
    exp_rd = 32'h0;
    if (!err && !we) exp_rd = h0 ? ref0[w] : ref1[w];
    if (!err && we && h0) ref0[w] = merge(ref0[w], wd, be);
    if (!err && we && h1) ref1[w] = merge(ref1[w], wd, be);
    s0 = we0_cnt;
    s1 = we1_cnt;
    @(negedge CLK_I);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_be    = be;
    bus.cpu_wdata = wd;
    n = 0;
    got_ack = 1'b0;
    while (n < 8 && !got_ack) begin
      @(posedge CLK_I);
      #1;
      n++;
      got_ack = bus.cpu_ack;
    end
    a_err = bus.cpu_err;
    a_rd  = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
    check_val("ack_latency", 32'(n), err ? 32'd1 : 32'd2);
    check_val("err", {31'b0, a_err}, {31'b0, err});
    check_val("rdata", a_rd, exp_rd);
    @(posedge CLK_I);
    #1;
    check_val("ack_one_cycle", {31'b0, bus.cpu_ack}, 32'd0);
    check_val("we0_pulses", 32'(we0_cnt - s0), {31'b0, !err && we && h0});
    check_val("we1_pulses", 32'(we1_cnt - s1), {31'b0, !err && we && h1});
    if (!err && we) begin
      check_val("strobe_add", {30'b0, last_add}, {30'b0, w});
      check_val("strobe_dat", last_dat, wd);
      check_val("strobe_be", {28'b0, last_be}, {28'b0, be});
    end
  endtask

  initial begin
    int          t1, n;
    logic        ok;
    logic [31:0] a;
    logic [3:0]  be;
    logic [3:0]  legal_list [7];
    logic        i0, i1;

    legal_list = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      dev0[i] = 32'h1000_0000 + i;
      dev1[i] = 32'h2000_0000 + i;
    end
    dev1[1] = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      ref0[i] = dev0[i];
      ref1[i] = dev1[i];
    end
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_be = '0; bus.cpu_wdata = '0; bus.IRQ0_I = 1'b0; bus.IRQ1_I = 1'b0;

    repeat (3) @(posedge CLK_I);
    #1;
    check_val("rst_ack", {31'b0, bus.cpu_ack}, 32'd0);
    check_val("rst_err", {31'b0, bus.cpu_err}, 32'd0);
    check_val("rst_rdata", bus.cpu_rdata, 32'd0);
    check_val("rst_add_dat", bus.DAT_O | {30'b0, bus.ADD_O}, 32'd0);
    check_val("rst_be_we", {26'b0, bus.BE_O, bus.WE0_O, bus.WE1_O}, 32'd0);
    check_val("rst_hwint", {26'b0, bus.HWINT_O}, 32'd0);
    RST_I = 1'b1;

    access(1'b1, 32'h0000_7F00, 4'b1111, 32'h0000_0009);
    access(1'b0, 32'h0000_7F14, 4'b1111, 32'h0);
    access(1'b1, 32'h0000_8000, 4'b1111, 32'hDEAD_BEEF);
    access(1'b1, 32'h0000_7F00, 4'b0110, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_7F20, 4'b1111, 32'h0);
    access(1'b0, 32'h0000_7F00, 4'b1111, 32'h0);

    // Reset asserted while the write strobe is up.
    @(negedge CLK_I);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_7F04;
    bus.cpu_be = 4'b1111; bus.cpu_wdata = 32'hCAFE_0001;
    @(posedge CLK_I);
    #1;
    check_val("wr_strobe_up", {31'b0, bus.WE0_O}, 32'd1);
    ref0[1] = 32'hCAFE_0001;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    bus.cpu_req = 1'b0;
    check_val("rst_wr_we", {30'b0, bus.WE0_O, bus.WE1_O}, 32'd0);
    check_val("rst_wr_ack", {31'b0, bus.cpu_ack}, 32'd0);
    check_val("rst_wr_outs", bus.DAT_O | {28'b0, bus.BE_O} | {30'b0, bus.ADD_O}, 32'd0);
    RST_I = 1'b1;
    repeat (2) begin
      @(posedge CLK_I);
      #1;
      check_val("rst_wr_no_ack", {31'b0, bus.cpu_ack}, 32'd0);
    end
    access(1'b0, 32'h0000_7F04, 4'b1111, 32'h0);

    // Two stores with cpu_req held high throughout.
    @(negedge CLK_I);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_7F18;
    bus.cpu_be = 4'b1111; bus.cpu_wdata = 32'hAAAA_0001;
    t1 = we1_cnt;
    n = 0; ok = 1'b0;
    while (n < 8 && !ok) begin @(posedge CLK_I); #1; n++; ok = bus.cpu_ack; end
    check_val("b2b_first_ack", {31'b0, ok}, 32'd1);
    a = 32'(cyc);
    bus.cpu_addr = 32'h0000_7F1C; bus.cpu_wdata = 32'hAAAA_0002;
    n = 0; ok = 1'b0;
    while (n < 8 && !ok) begin @(posedge CLK_I); #1; n++; ok = bus.cpu_ack; end
    bus.cpu_req = 1'b0;
    check_val("b2b_ack_gap", 32'(cyc) - a, 32'd3);
    @(posedge CLK_I);
    #1;
    check_val("b2b_we_pulses", 32'(we1_cnt - t1), 32'd2);
    ref1[2] = 32'hAAAA_0001;
    ref1[3] = 32'hAAAA_0002;
    access(1'b0, 32'h0000_7F18, 4'b1111, 32'h0);
    access(1'b0, 32'h0000_7F1C, 4'b1111, 32'h0);

    // IRQ capture.
    @(negedge CLK_I);
    bus.IRQ0_I = 1'b1;
    @(posedge CLK_I);
    #1;
    check_val("irq0_rise", {26'b0, bus.HWINT_O}, 32'b000001);
    bus.IRQ0_I = 1'b0;
    @(posedge CLK_I);
    #1;
    check_val("irq0_fall", {26'b0, bus.HWINT_O}, 32'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK_I);
      i0 = 1'($urandom);
      i1 = 1'($urandom);
      bus.IRQ0_I = i0;
      bus.IRQ1_I = i1;
      @(posedge CLK_I);
      #1;
      check_val("irq_rand", {26'b0, bus.HWINT_O}, {30'b0, i1, i0});
    end
    bus.IRQ0_I = 1'b0;
    bus.IRQ1_I = 1'b0;

    // Random traffic, mostly inside the two windows.
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'h0000_7F20 + $urandom_range(0, 31);
        2:       a = 32'h0000_7EF0 + $urandom_range(0, 15);
        default: a = 32'h0000_7F00 + $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) == 0) be = 4'($urandom);
      else be = legal_list[$urandom_range(0, 6)];
      access(1'($urandom), a, be, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
